// File: rtl/arb_pkg.sv
// Shared arbiter definitions: state encoding, master count and owner index width.
// Also used by the FCFS arbiter so both sides agree on the encoding.
package arb_pkg;

    localparam int unsigned NumMasters = 4;
    localparam int unsigned IdxW       = 2;
    localparam int unsigned CntW       = $clog2(NumMasters + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StDone = 2'd2,
        StRel  = 2'd3
    } arb_state_e;

    function automatic logic [NumMasters-1:0] idx_to_onehot(input logic [IdxW-1:0] idx);
        return NumMasters'(1) << idx;
    endfunction

endpackage

// File: rtl/onehot_check.sv
// Classifies a grant vector: exactly one bit set, more than one set, and the
// index of the lowest set bit.
module onehot_check
    import arb_pkg::*;
(
    input  logic [NumMasters-1:0] grant_i,
    output logic                  valid_onehot_o,
    output logic                  multi_o,
    output logic [IdxW-1:0]       idx_o
);

    logic [CntW-1:0] cnt;

    always_comb begin
        cnt   = '0;
        idx_o = '0;
        // Walk downward so the lowest set bit is the index left standing.
        for (int i = NumMasters - 1; i >= 0; i--) begin
            if (grant_i[i]) begin
                cnt   = cnt + CntW'(1);
                idx_o = IdxW'(i);
            end
        end
        valid_onehot_o = (cnt == CntW'(1));
        multi_o        = (cnt > CntW'(1));
    end

endmodule

// File: rtl/arb_burst_mux.sv
// Routes the granted master's burst onto the shared slave port, counts beats,
// pulses Done on completion and Err on multi-grant, grant drop or stall timeout.
module arb_burst_mux
    import arb_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned LW      = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          Grant0,
    input  logic          Grant1,
    input  logic          Grant2,
    input  logic          Grant3,
    input  logic [DW-1:0] Wdata0,
    input  logic [DW-1:0] Wdata1,
    input  logic [DW-1:0] Wdata2,
    input  logic [DW-1:0] Wdata3,
    input  logic          Wvalid0,
    input  logic          Wvalid1,
    input  logic          Wvalid2,
    input  logic          Wvalid3,
    input  logic [LW-1:0] Blen0,
    input  logic [LW-1:0] Blen1,
    input  logic [LW-1:0] Blen2,
    input  logic [LW-1:0] Blen3,
    output logic          Wready0,
    output logic          Wready1,
    output logic          Wready2,
    output logic          Wready3,
    output logic          Done0,
    output logic          Done1,
    output logic          Done2,
    output logic          Done3,
    output logic [DW-1:0] Mdata,
    output logic          Mvalid,
    input  logic          Mready,
    output logic [1:0]    Mowner,
    output logic          Busy,
    output logic          Err
);

    localparam int unsigned SW = $clog2(TIMEOUT + 1);

    logic [NumMasters-1:0] grant_vec;
    logic [NumMasters-1:0] wvalid_vec;
    logic [NumMasters-1:0] wready_vec;
    logic [NumMasters-1:0] done_vec;
    logic [DW-1:0]         wdata_arr [NumMasters];
    logic [LW-1:0]         blen_arr  [NumMasters];

    assign grant_vec  = {Grant3, Grant2, Grant1, Grant0};
    assign wvalid_vec = {Wvalid3, Wvalid2, Wvalid1, Wvalid0};
    assign wdata_arr[0] = Wdata0;
    assign wdata_arr[1] = Wdata1;
    assign wdata_arr[2] = Wdata2;
    assign wdata_arr[3] = Wdata3;
    assign blen_arr[0]  = Blen0;
    assign blen_arr[1]  = Blen1;
    assign blen_arr[2]  = Blen2;
    assign blen_arr[3]  = Blen3;

    assign {Wready3, Wready2, Wready1, Wready0} = wready_vec;
    assign {Done3, Done2, Done1, Done0}         = done_vec;

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            gnt_single;
    logic            gnt_multi;
    logic [IdxW-1:0] gnt_idx;

    onehot_check u_onehot_check (
        .grant_i        (grant_vec),
        .valid_onehot_o (gnt_single),
        .multi_o        (gnt_multi),
        .idx_o          (gnt_idx)
    );

    logic          owner_gnt;
    logic          in_xfer;
    logic          xfer_live;
    logic          beat;
    logic [SW-1:0] stall_inc;

    // Slave path is a pure pass-through; a dropped owner grant gates it off.
    always_comb begin
        owner_gnt  = grant_vec[owner_q];
        in_xfer    = (state_q == StXfer);
        xfer_live  = in_xfer && owner_gnt;
        Mvalid     = xfer_live && wvalid_vec[owner_q];
        Mdata      = in_xfer ? wdata_arr[owner_q] : '0;
        wready_vec = '0;
        if (xfer_live) begin
            wready_vec[owner_q] = Mready;
        end
        beat      = Mvalid && Mready;
        stall_inc = stall_cnt_q + SW'(1);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (gnt_multi) begin
                    err_d = 1'b1;
                end else if (gnt_single) begin
                    owner_d     = gnt_idx;
                    len_d       = blen_arr[gnt_idx];
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = StXfer;
                end
            end
            StXfer: begin
                if (!owner_gnt) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (beat) begin
                    stall_cnt_d = '0;
                    // Compare before incrementing so len = 2^LW-1 never wraps.
                    if (beat_cnt_q == len_q) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LW'(1);
                    end
                end else if (stall_inc == SW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall_cnt_d = stall_inc;
                end
            end
            StDone: begin
                state_d = StRel;
            end
            StRel: begin
                if (!owner_gnt) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign done_vec = done_q ? idx_to_onehot(owner_q) : '0;
    assign Mowner   = owner_q;
    assign Busy     = (state_q != StIdle);
    assign Err      = err_q;

endmodule

// File: tb/tb_arb_burst_mux.sv
// Scoreboard bench for arb_burst_mux: drivers queue expected beats, Done and Err
// events; a negedge monitor pops and compares as the DUT presents them.
module tb_arb_burst_mux;

    localparam int DW = 8;
    localparam int LW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          resetn;
    logic [3:0]    grant;
    logic [3:0]    wvalid;
    logic [DW-1:0] wdata [4];
    logic [LW-1:0] blen_a [4];
    logic          mready;
    logic [3:0]    wready;
    logic [3:0]    done;
    logic [DW-1:0] mdata;
    logic          mvalid;
    logic [1:0]    mowner;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scoreboard queues
    int            exp_own_q [$];
    logic [DW-1:0] exp_dat_q [$];
    int            done_exp_q [$];
    int            err_exp_q [$];
    logic [DW-1:0] cur_data [$];

    arb_burst_mux #(.DW(DW), .LW(LW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .Grant0  (grant[0]),
        .Grant1  (grant[1]),
        .Grant2  (grant[2]),
        .Grant3  (grant[3]),
        .Wdata0  (wdata[0]),
        .Wdata1  (wdata[1]),
        .Wdata2  (wdata[2]),
        .Wdata3  (wdata[3]),
        .Wvalid0 (wvalid[0]),
        .Wvalid1 (wvalid[1]),
        .Wvalid2 (wvalid[2]),
        .Wvalid3 (wvalid[3]),
        .Blen0   (blen_a[0]),
        .Blen1   (blen_a[1]),
        .Blen2   (blen_a[2]),
        .Blen3   (blen_a[3]),
        .Wready0 (wready[0]),
        .Wready1 (wready[1]),
        .Wready2 (wready[2]),
        .Wready3 (wready[3]),
        .Done0   (done[0]),
        .Done1   (done[1]),
        .Done2   (done[2]),
        .Done3   (done[3]),
        .Mdata   (mdata),
        .Mvalid  (mvalid),
        .Mready  (mready),
        .Mowner  (mowner),
        .Busy    (busy),
        .Err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every slave beat, Done pulse and Err pulse against the queues.
    int            mon_own;
    logic [DW-1:0] mon_dat;
    int            mon_err;
    always @(negedge clk) begin
        if (resetn) begin
            if (mvalid && mready) begin
                if (exp_dat_q.size() == 0) begin
                    chk("unexpected_beat", 32'(mdata), 32'hdead_beef);
                end else begin
                    mon_own = exp_own_q.pop_front();
                    mon_dat = exp_dat_q.pop_front();
                    chk("beat_data", 32'(mdata), 32'(mon_dat));
                    chk("beat_owner", 32'(mowner), 32'(mon_own));
                    chk("beat_wready", 32'(wready), 32'(4'b0001 << mon_own));
                end
            end
            if (done != 4'b0000) begin
                if (done_exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'h0);
                end else begin
                    mon_own = done_exp_q.pop_front();
                    chk("done_vec", 32'(done), 32'(4'b0001 << mon_own));
                    chk("done_mowner", 32'(mowner), 32'(mon_own));
                    chk("done_all_beats", 32'(exp_dat_q.size()), 32'h0);
                end
            end
            if (err) begin
                if (err_exp_q.size() == 0) begin
                    chk("unexpected_err", 32'(err), 32'h0);
                end else begin
                    mon_err = err_exp_q.pop_front();
                    chk("err_cycle", 32'(cyc), 32'(mon_err));
                    chk("err_busy", 32'(busy), 32'h0);
                    chk("err_no_done", 32'(done), 32'h0);
                end
            end
        end
    end

    // Master-side driver: presents cur_data words, advancing on each accepted beat.
    task automatic drive_beats(input int m, input int n, input bit rnd);
        int   idx    = 0;
        int   stall  = 0;
        int   budget = 400;
        logic v;
        logic r;
        logic hs;
        while (idx < n && budget > 0) begin
            v = rnd ? (stall >= 3 || $urandom_range(0, 3) != 0) : 1'b1;
            r = rnd ? (stall >= 3 || $urandom_range(0, 3) != 0) : 1'b1;
            wvalid[m] = v;
            wdata[m]  = cur_data[idx];
            mready    = r;
            @(negedge clk);
            hs    = v && wready[m];
            stall = hs ? 0 : stall + 1;
            @(posedge clk);
            #1;
            if (hs) idx++;
            budget--;
        end
        wvalid[m] = 1'b0;
        mready    = 1'b0;
        chk("beat_budget", 32'(idx), 32'(n));
    endtask

    task automatic load_burst(input int m, input int blen, input int nexp);
        cur_data.delete();
        for (int k = 0; k <= blen; k++) begin
            cur_data.push_back(DW'($urandom));
            if (k < nexp) begin
                exp_own_q.push_back(m);
                exp_dat_q.push_back(cur_data[k]);
            end
        end
        blen_a[m] = LW'(blen);
    endtask

    // Full burst: blen+1 beats, Done right after the last beat, Busy drops one
    // cycle after the grant is released.
    task automatic run_burst(input int m, input int blen, input bit rnd);
        load_burst(m, blen, blen + 1);
        done_exp_q.push_back(m);
        grant[m] = 1'b1;
        drive_beats(m, blen + 1, rnd);
        @(negedge clk);
        chk("done_timing", 32'(done), 32'(4'b0001 << m));
        @(posedge clk);
        #1;
        grant[m] = 1'b0;
        @(negedge clk);
        chk("busy_in_rel", 32'(busy), 32'h1);
        @(negedge clk);
        chk("busy_drop", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        resetn = 1'b0;
        grant  = '0;
        wvalid = '0;
        mready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdata[i]  = '0;
            blen_a[i] = '0;
        end
        #3;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mvalid", 32'(mvalid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_mowner", 32'(mowner), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed: 4 beats from master 1, then single beat from master 2 with stalls.
        run_burst(1, 3, 1'b0);
        run_burst(2, 0, 1'b1);

        // Stall timeout: Mready held low.
        grant[3]  = 1'b1;
        wvalid[3] = 1'b1;
        mready    = 1'b0;
        blen_a[3] = 4'd5;
        c = cyc;
        err_exp_q.push_back(c + 1 + TO);
        repeat (1 + TO) @(posedge clk);
        #1;
        grant[3]  = 1'b0;
        wvalid[3] = 1'b0;
        @(posedge clk);
        #1;
        chk("timeout_err_seen", 32'(err_exp_q.size()), 32'h0);
        chk("timeout_idle", 32'(busy), 32'h0);

        // Grant drop after 2 of 4 beats.
        load_burst(0, 3, 2);
        grant[0] = 1'b1;
        c = cyc;
        drive_beats(0, 2, 1'b0);
        wvalid[0] = 1'b1;
        mready    = 1'b1;
        grant[0]  = 1'b0;
        err_exp_q.push_back(c + 4);
        @(negedge clk);
        chk("drop_mvalid", 32'(mvalid), 32'h0);
        chk("drop_wready", 32'(wready), 32'h0);
        @(posedge clk);
        #1;
        wvalid[0] = 1'b0;
        mready    = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_err_seen", 32'(err_exp_q.size()), 32'h0);
        run_burst(3, 2, 1'b0);

        // Multi-grant in IDLE.
        grant = 4'b0101;
        err_exp_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        grant = 4'b0000;
        @(negedge clk);
        chk("multi_no_capture", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        chk("multi_err_seen", 32'(err_exp_q.size()), 32'h0);
        chk("multi_still_idle", 32'(busy), 32'h0);

        // Async reset mid-burst, then a maximum-length burst.
        load_burst(1, 7, 8);
        grant[1] = 1'b1;
        drive_beats(1, 3, 1'b0);
        wvalid[1] = 1'b1;
        mready    = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_mvalid", 32'(mvalid), 32'h0);
        chk("arst_wready", 32'(wready), 32'h0);
        chk("arst_mdata", 32'(mdata), 32'h0);
        chk("arst_mowner", 32'(mowner), 32'h0);
        exp_own_q.delete();
        exp_dat_q.delete();
        grant     = '0;
        wvalid    = '0;
        mready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_burst(0, 15, 1'b0);

        // Randomized bursts.
        for (int i = 0; i < 20; i++) begin
            run_burst($urandom_range(0, 3), $urandom_range(0, 15), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("end_beats_empty", 32'(exp_dat_q.size()), 32'h0);
        chk("end_done_empty", 32'(done_exp_q.size()), 32'h0);
        chk("end_err_empty", 32'(err_exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
